// File: rtl/updown_counter.sv
// Up/down modulo counter advanced by an asynchronous step input.
// step_in is synchronized and edge-detected; count, count_n and tc are all registered.
module updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX      = 15,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step_in,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_n,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic             s1_q, s2_q, s3_q;
  logic             step;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] count_n_q;
  logic             tc_q, tc_d;

  // s1 is the metastability stage; s2/s3 give a single-cycle rising-edge pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= step_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign step = s2_q & ~s3_q;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (step && en) begin
      if (dir) begin
        if (count_q == MAX_V) begin
          tc_d = 1'b1;
          if (!SATURATE) count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          tc_d = 1'b1;
          if (!SATURATE) count_d = MAX_V;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  // count_n is registered from count_d so it never lags count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      count_n_q <= '1;
      tc_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      count_n_q <= ~count_d;
      tc_q      <= tc_d;
    end
  end

  assign count   = count_q;
  assign count_n = count_n_q;
  assign tc      = tc_q;

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: one wrapping and one saturating instance (MAX=9) share all inputs.
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, dir, load, step_in;
  logic [3:0] load_val;
  logic [3:0] cnt0, cntn0, cnt1, cntn1;
  logic       tc0, tc1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .step_in(step_in), .count(cnt0), .count_n(cntn0), .tc(tc0));

  updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .step_in(step_in), .count(cnt1), .count_n(cntn1), .tc(tc1));

  // Reference model: step_in sample history plus plain-arithmetic count rules.
  logic [3:0] m_cnt[2];
  logic       m_tc[2];
  logic [2:0] hist;   // hist[0] = sample at previous edge, hist[2] = three edges back

  task automatic model_reset();
    hist = '0;
    for (int s = 0; s < 2; s++) begin
      m_cnt[s] = 4'd0;
      m_tc[s]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic stp;
    if (rst) return;
    stp  = hist[1] & ~hist[2];
    hist = {hist[1:0], step_in};
    for (int s = 0; s < 2; s++) begin
      m_tc[s] = 1'b0;
      if (load) begin
        m_cnt[s] = (load_val > 4'd9) ? 4'd9 : load_val;
      end else if (stp && en) begin
        if (dir && m_cnt[s] == 4'd9) begin
          m_tc[s]  = 1'b1;
          m_cnt[s] = (s == 1) ? 4'd9 : 4'd0;
        end else if (!dir && m_cnt[s] == 4'd0) begin
          m_tc[s]  = 1'b1;
          m_cnt[s] = (s == 1) ? 4'd0 : 4'd9;
        end else begin
          m_cnt[s] = dir ? m_cnt[s] + 4'd1 : m_cnt[s] - 4'd1;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("wrap.count",   cnt0,  m_cnt[0]);
    chk("wrap.count_n", cntn0, ~m_cnt[0]);
    chk("wrap.tc",      {3'b0, tc0}, {3'b0, m_tc[0]});
    chk("sat.count",    cnt1,  m_cnt[1]);
    chk("sat.count_n",  cntn1, ~m_cnt[1]);
    chk("sat.tc",       {3'b0, tc1}, {3'b0, m_tc[1]});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk_model();
  endtask

  // Called right after a tick: asserts rst mid-cycle and checks the outputs before any edge.
  task automatic async_reset();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst.count0",   cnt0,  4'h0);
    chk("rst.count_n0", cntn0, 4'hF);
    chk("rst.tc0",      {3'b0, tc0}, 4'h0);
    chk("rst.count1",   cnt1,  4'h0);
    chk("rst.count_n1", cntn1, 4'hF);
    chk("rst.tc1",      {3'b0, tc1}, 4'h0);
  endtask

  task automatic pulse(input logic d);
    dir = d;
    step_in = 1'b1;
    tick();
    step_in = 1'b0;
    tick();
    tick();
  endtask

  typedef struct packed {
    logic       ld;
    logic [3:0] lv;
    logic       en;
    logic       dir;
    logic       si;
    logic [3:0] cnt;
    logic       tc;
  } vec_t;

  vec_t       tv[24];
  logic [3:0] sat_cnt[4];
  logic       sat_tc[4];
  logic [3:0] e;

  initial begin
    tv[0]  = '{1'b1, 4'd3,  1'b1, 1'b1, 1'b0, 4'd3, 1'b0};
    tv[1]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd3, 1'b0};
    tv[2]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd3, 1'b0};
    tv[3]  = '{1'b1, 4'd7,  1'b1, 1'b1, 1'b0, 4'd7, 1'b0};
    tv[4]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd7, 1'b0};
    tv[5]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd7, 1'b0};
    tv[6]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd7, 1'b0};
    tv[7]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd8, 1'b0};
    tv[8]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd8, 1'b0};
    tv[9]  = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd8, 1'b0};
    tv[10] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd9, 1'b0};
    tv[11] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd9, 1'b0};
    tv[12] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd9, 1'b0};
    tv[13] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd0, 1'b1};
    tv[14] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd0, 1'b0};
    tv[15] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd0, 1'b0};
    tv[16] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd0, 1'b0};
    tv[17] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
    tv[18] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd0, 1'b0};
    tv[19] = '{1'b1, 4'd13, 1'b1, 1'b1, 1'b0, 4'd9, 1'b0};
    tv[20] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd9, 1'b0};
    tv[21] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd9, 1'b0};
    tv[22] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd8, 1'b0};
    tv[23] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd8, 1'b0};
    sat_cnt = '{4'd1, 4'd0, 4'd0, 4'd0};
    sat_tc  = '{1'b0, 1'b0, 1'b1, 1'b1};

    rst = 1'b1; en = 1'b1; dir = 1'b1; load = 1'b0; load_val = 4'd0; step_in = 1'b0;
    model_reset();
    tick();
    tick();
    #3 rst = 1'b0;
    repeat (3) tick();

    // Asynchronous reset while counting
    load = 1'b1; load_val = 4'd5;
    tick();
    load = 1'b0;
    async_reset();
    tick();
    #3 rst = 1'b0;
    repeat (3) tick();

    // Table-driven vectors, expectations for the wrapping instance
    for (int r = 0; r < 24; r++) begin
      load = tv[r].ld; load_val = tv[r].lv; en = tv[r].en; dir = tv[r].dir; step_in = tv[r].si;
      tick();
      chk($sformatf("tbl[%0d].count", r), cnt0, tv[r].cnt);
      chk($sformatf("tbl[%0d].tc", r), {3'b0, tc0}, {3'b0, tv[r].tc});
    end
    load = 1'b0; en = 1'b1; dir = 1'b1; step_in = 1'b0;
    repeat (3) tick();

    // Up count with wrap from 0, checking two-edge latency
    load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      e = (i == 9) ? 4'd0 : 4'(i + 1);
      step_in = 1'b1;
      tick();
      step_in = 1'b0;
      tick();
      chk("wrap.latency_hold", cnt0, 4'(i));
      tick();
      chk("wrap.step", cnt0, e);
      chk("wrap.tc_pulse", {3'b0, tc0}, (i == 9) ? 4'd1 : 4'd0);
    end
    tick();
    chk("wrap.tc_drop", {3'b0, tc0}, 4'd0);

    // Down count with saturation from 2
    load = 1'b1; load_val = 4'd2;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pulse(1'b0);
      chk("satdn.count", cnt1, sat_cnt[i]);
      chk("satdn.count_n", cntn1, ~sat_cnt[i]);
    end
    // tc is sampled right at the update edge inside a step
    load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      dir = 1'b0; step_in = 1'b1;
      tick();
      step_in = 1'b0;
      tick();
      tick();
      chk("satdn.tc_at_zero", {3'b0, tc1}, 4'd1);
    end

    // Held step_in gives one increment; dir toggles between steps
    dir = 1'b1;
    load = 1'b1; load_val = 4'd4;
    tick();
    load = 1'b0;
    step_in = 1'b1;
    repeat (20) tick();
    step_in = 1'b0;
    repeat (3) tick();
    chk("held.count", cnt0, 4'd5);
    pulse(1'b0);
    chk("dir.down", cnt0, 4'd4);
    pulse(1'b1);
    chk("dir.up", cnt0, 4'd5);

    // Reset between E0 and E2 cancels the pending step
    step_in = 1'b1;
    tick();
    async_reset();
    step_in = 1'b0;
    tick();
    tick();
    #3 rst = 1'b0;
    repeat (4) tick();
    chk("cancel.count", cnt0, 4'd0);

    // step_in held through reset yields exactly one step after release
    dir = 1'b1;
    step_in = 1'b1;
    tick();
    async_reset();
    tick();
    tick();
    #3 rst = 1'b0;
    repeat (6) tick();
    chk("held_rst.count", cnt0, 4'd1);
    step_in = 1'b0;
    repeat (3) tick();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      load     = ($urandom_range(0, 15) == 0);
      load_val = 4'($urandom_range(0, 15));
      en       = ($urandom_range(0, 3) != 0);
      dir      = 1'($urandom_range(0, 1));
      step_in  = 1'($urandom_range(0, 1));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
